// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fm_pkg
//  Description : Shared definitions for the FM slot sequencer and the operator
//                datapath: FSM state encoding, word-unpacking helpers and
//                default slot timing.
//  Revision    : 1.0 - initial release
// ============================================================================
package fm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SLOT = 2'd1,
      ST_DONE = 2'd2
   } fm_state_e;

   localparam int c_def_num_bits    = 32;
   localparam int c_def_num_chan    = 16;
   localparam int c_def_step        = 6;
   localparam int c_def_latency     = 3;
   localparam int c_def_note_en_pos = c_def_num_bits - 1;

   // The note enable lives in the MSB of each carrier word.
   function automatic int note_en_pos(input int num_bits);
      return num_bits - 1;
   endfunction

endpackage : fm_pkg
`default_nettype wire

// File: rtl/fm_slot_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fm_slot_sequencer_if
//  Description : Bus between the voice register file / host (master) and the
//                slot sequencer (slave).
//                master drives : start, skip_idle, carrier_in, modulator_in,
//                                available
//                slave drives  : note_en, mod_acc_clr, slot strobes,
//                                curr_note, curr_ch, words, status, s_clk*
//  Revision    : 1.0 - initial release
// ============================================================================
interface fm_slot_sequencer_if #(
   parameter int NUM_BITS     = fm_pkg::c_def_num_bits,
   parameter int NUM_CHANNELS = fm_pkg::c_def_num_chan,
   parameter int CH_W         = $clog2(NUM_CHANNELS)
);
   logic                           start;
   logic                           skip_idle;
   logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_in;
   logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_in;
   logic [NUM_CHANNELS-1:0]        available;

   logic [NUM_CHANNELS-1:0]        note_en;
   logic [NUM_CHANNELS-1:0]        mod_acc_clr;
   logic [NUM_CHANNELS-1:0]        mod_acc_en;
   logic [NUM_CHANNELS-1:0]        mod_reg_en;
   logic [NUM_CHANNELS-1:0]        car_acc_en;
   logic [NUM_CHANNELS-1:0]        car_reg_en;
   logic [NUM_CHANNELS-1:0]        curr_note;
   logic [CH_W-1:0]                curr_ch;
   logic [NUM_BITS-1:0]            carrier_word;
   logic [NUM_BITS-1:0]            mod_word;
   logic                           busy;
   logic                           frame_done;
   logic                           overrun;
   logic                           interrupt_out;
   logic                           s_clk;
   logic                           s_clk_pos;
   logic                           s_clk_neg;

   modport master (
      output start, skip_idle, carrier_in, modulator_in, available,
      input  note_en, mod_acc_clr, mod_acc_en, mod_reg_en, car_acc_en,
             car_reg_en, curr_note, curr_ch, carrier_word, mod_word, busy,
             frame_done, overrun, interrupt_out, s_clk, s_clk_pos, s_clk_neg
   );

   modport slave (
      input  start, skip_idle, carrier_in, modulator_in, available,
      output note_en, mod_acc_clr, mod_acc_en, mod_reg_en, car_acc_en,
             car_reg_en, curr_note, curr_ch, carrier_word, mod_word, busy,
             frame_done, overrun, interrupt_out, s_clk, s_clk_pos, s_clk_neg
   );

endinterface : fm_slot_sequencer_if
`default_nettype wire

// File: rtl/fm_next_channel.sv
`default_nettype none
// ============================================================================
//  Module      : fm_next_channel
//  Description : Combinational search for the lowest eligible channel strictly
//                above cur_idx_i (or at/above 0 when from_zero_i is set).
//                cur_idx_i   : current channel index
//                elig_i      : per-channel eligibility mask
//                from_zero_i : search from channel 0 inclusive
//                found_o     : an eligible channel exists
//                next_idx_o  : its index (0 when none found)
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_next_channel #(
   parameter int NUM_CHANNELS = 16,
   parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
   input  logic [CH_W-1:0]         cur_idx_i,
   input  logic [NUM_CHANNELS-1:0] elig_i,
   input  logic                    from_zero_i,
   output logic                    found_o,
   output logic [CH_W-1:0]         next_idx_o
);

   // Descending scan so the last hit written is the lowest qualifying index.
   always_comb begin
      found_o    = 1'b0;
      next_idx_o = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (elig_i[i] && (from_zero_i || (i > int'(cur_idx_i)))) begin
            found_o    = 1'b1;
            next_idx_o = CH_W'(i);
         end
      end
   end

endmodule : fm_next_channel
`default_nettype wire

// File: rtl/fm_slot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fm_slot_sequencer
//  Description : Time-multiplexed channel slot sequencer for the FM synth.
//                On start it walks eligible channels in ascending order, each
//                for STEP cycles, issuing one-hot slot strobes and presenting
//                the active channel's carrier/modulator words. Also hosts a
//                free-running sample-clock divider.
//                clk, rst : clock, synchronous active-high reset
//                bus      : fm_slot_sequencer_if.slave (all data/status)
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_slot_sequencer
   import fm_pkg::*;
#(
   parameter int NUM_BITS     = c_def_num_bits,
   parameter int NUM_CHANNELS = c_def_num_chan,
   parameter int STEP         = c_def_step,
   parameter int LATENCY      = c_def_latency,
   parameter int SCLK_DIV     = 4,
   parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   fm_slot_sequencer_if.slave  bus
);

   localparam int C_W   = $clog2(STEP);
   localparam int D_W   = $clog2(SCLK_DIV);
   localparam int NEP   = note_en_pos(NUM_BITS);

   // ---------------------------------------------------------------- unpack
   logic [NUM_BITS-1:0]     w_car [NUM_CHANNELS];
   logic [NUM_BITS-1:0]     w_mod [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] w_note_en;
   logic [NUM_CHANNELS-1:0] w_mod_zero;
   logic [NUM_CHANNELS-1:0] w_elig;

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_unpack
      assign w_car[k]      = bus.carrier_in[k*NUM_BITS +: NUM_BITS];
      assign w_mod[k]      = bus.modulator_in[k*NUM_BITS +: NUM_BITS];
      assign w_note_en[k]  = w_car[k][NEP];
      assign w_mod_zero[k] = (w_mod[k] == '0);
   end

   assign w_elig            = bus.skip_idle ? w_note_en : '1;
   assign bus.note_en       = w_note_en;
   assign bus.mod_acc_clr   = w_mod_zero;
   assign bus.interrupt_out = |bus.available;

   // ------------------------------------------------------------------- FSM
   fm_state_e       state_q, state_d;
   logic [C_W-1:0]  c_q, c_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic            w_found;
   logic [CH_W-1:0] w_next;

   fm_next_channel #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .CH_W         (CH_W)
   ) u_next (
      .cur_idx_i   (ch_q),
      .elig_i      (w_elig),
      .from_zero_i (state_q == ST_IDLE),
      .found_o     (w_found),
      .next_idx_o  (w_next)
   );

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      ch_d    = ch_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               c_d = '0;
               if (w_found) begin
                  state_d = ST_SLOT;
                  ch_d    = w_next;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SLOT: begin
            if (c_q == C_W'(STEP - 1)) begin
               c_d = '0;
               if (w_found) begin
                  ch_d = w_next;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               c_d = c_q + C_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from next-state so they line up with the slot
   // the FSM is entering on this edge.
   logic [NUM_CHANNELS-1:0] curr_note_d, mae_d, mre_d, cae_d, cre_d;
   logic                    w_in_slot;
   logic                    w_enter;

   assign w_in_slot = (state_d == ST_SLOT);
   assign w_enter   = w_in_slot && (c_d == '0);

   always_comb begin
      curr_note_d = '0;
      mae_d       = '0;
      mre_d       = '0;
      cae_d       = '0;
      cre_d       = '0;
      if (w_in_slot) begin
         curr_note_d[ch_d] = 1'b1;
         if (c_d == '0)                 mae_d[ch_d] = 1'b1;
         if (c_d == C_W'(LATENCY - 1))  mre_d[ch_d] = 1'b1;
         if (c_d == C_W'(LATENCY))      cae_d[ch_d] = 1'b1;
         if (c_d == C_W'(STEP - 1))     cre_d[ch_d] = 1'b1;
      end
   end

   logic [NUM_CHANNELS-1:0] curr_note_q, mae_q, mre_q, cae_q, cre_q;
   logic [CH_W-1:0]         curr_ch_q;
   logic [NUM_BITS-1:0]     car_word_q, mod_word_q;
   logic                    busy_q, frame_done_q, overrun_q;
   logic [D_W-1:0]          d_q;
   logic                    s_clk_pos_q, s_clk_neg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         c_q          <= '0;
         ch_q         <= '0;
         curr_note_q  <= '0;
         mae_q        <= '0;
         mre_q        <= '0;
         cae_q        <= '0;
         cre_q        <= '0;
         curr_ch_q    <= '0;
         car_word_q   <= '0;
         mod_word_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         d_q          <= '0;
         s_clk_pos_q  <= 1'b0;
         s_clk_neg_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         c_q          <= c_d;
         ch_q         <= ch_d;
         curr_note_q  <= curr_note_d;
         mae_q        <= mae_d;
         mre_q        <= mre_d;
         cae_q        <= cae_d;
         cre_q        <= cre_d;
         curr_ch_q    <= w_in_slot ? ch_d : '0;
         busy_q       <= w_in_slot;
         frame_done_q <= (state_d == ST_DONE);
         overrun_q    <= bus.start && (state_q != ST_IDLE);
         // Words are captured only on slot entry and otherwise hold.
         if (w_enter) begin
            car_word_q <= {1'b0, w_car[ch_d][NUM_BITS-2:0]};
            mod_word_q <= w_mod[ch_d];
         end
         // Sample-clock divider runs regardless of the FSM.
         d_q          <= (d_q == D_W'(SCLK_DIV - 1)) ? '0 : d_q + D_W'(1);
         s_clk_pos_q  <= (d_q == '0);
         s_clk_neg_q  <= (d_q == D_W'(SCLK_DIV / 2));
      end
   end

   assign bus.curr_note    = curr_note_q;
   assign bus.mod_acc_en   = mae_q;
   assign bus.mod_reg_en   = mre_q;
   assign bus.car_acc_en   = cae_q;
   assign bus.car_reg_en   = cre_q;
   assign bus.curr_ch      = curr_ch_q;
   assign bus.carrier_word = car_word_q;
   assign bus.mod_word     = mod_word_q;
   assign bus.busy         = busy_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.overrun      = overrun_q;
   assign bus.s_clk        = (d_q >= D_W'(SCLK_DIV / 2));
   assign bus.s_clk_pos    = s_clk_pos_q;
   assign bus.s_clk_neg    = s_clk_neg_q;

endmodule : fm_slot_sequencer
`default_nettype wire

// File: doc/fm_slot_sequencer.md
Name: fm_slot_sequencer

Overview:
- Time-multiplexed slot sequencer for the FM synthesizer. It is the parametrised successor to the fixed one-hot channel scheduler.
- On each frame start it walks the channels in ascending order. Each channel gets a STEP-cycle slot with programmable strobe positions, and the active channel's carrier/modulator words are presented on registered outputs.
- Adds over the previous generation: runtime skipping of idle channels, explicit busy/frame_done/overrun status, and a parametrised sample-clock divider.
- Sits between the voice register file (carrier_in/modulator_in/available) and the shared operator datapath.

Parameters:
- NUM_BITS, 32: width of one carrier/modulator word.
- NUM_CHANNELS, 16: number of voices (>=2).
- STEP, 6: clock cycles per channel slot (>=3).
- LATENCY, 3: operator pipeline latency; 1 <= LATENCY <= STEP-2.
- SCLK_DIV, 4: sample clock period in clk cycles; even, >=2.
- CH_W, $clog2(NUM_CHANNELS): channel index width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse
- skip_idle  in  1  1 = skip channels whose note_en=0
- carrier_in  in  NUM_BITS*NUM_CHANNELS  packed carriers; MSB of each word is that channel's note enable
- modulator_in  in  NUM_BITS*NUM_CHANNELS  packed modulators
- available  in  NUM_CHANNELS  free-voice flags
- note_en  out  NUM_CHANNELS  MSB of each carrier word (combinational)
- mod_acc_clr  out  NUM_CHANNELS  1 when that channel's modulator word == 0 (combinational)
- mod_acc_en, mod_reg_en, car_acc_en, car_reg_en  out  NUM_CHANNELS each  one-hot slot strobes
- curr_note  out  NUM_CHANNELS  one-hot active channel, high for the whole slot
- curr_ch  out  CH_W  index of the active channel
- carrier_word  out  NUM_BITS  {1'b0, carrier bits [NUM_BITS-2:0]} of the active channel
- mod_word  out  NUM_BITS  modulator word of the active channel
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last slot
- overrun  out  1  one-cycle pulse when start arrives while busy
- interrupt_out  out  1  |available (combinational)
- s_clk, s_clk_pos, s_clk_neg  out  1 each  sample clock and its edge pulses

Behaviour:
- Reset (rst=1 at a clk edge): every registered output is 0 (curr_ch, words, strobes, curr_note, busy, frame_done, overrun, s_clk_pos, s_clk_neg). Slot counter and divider counter are 0. Reset mid-frame aborts the frame immediately, with no frame_done.
- FSM states: IDLE, SLOT, DONE.
- IDLE: on start=1, select the first eligible channel at or above 0 and go to SLOT with slot counter c=0. If no channel is eligible, go to DONE instead.
  - A channel is eligible when skip_idle=0, or when its note_en=1.
  - skip_idle and note_en are sampled at each selection edge.
- SLOT:
  - c counts 0..STEP-1. busy=1.
  - curr_note[k]=1 and curr_ch=k throughout the slot.
  - mod_acc_en[k]=1 at c=0.
  - mod_reg_en[k]=1 at c=LATENCY-1. When LATENCY=1 this coincides with mod_acc_en.
  - car_acc_en[k]=1 at c=LATENCY.
  - car_reg_en[k]=1 at c=STEP-1.
  - At c=STEP-1, select the next eligible channel above k:
    - if found, re-enter SLOT with c=0;
    - else go to DONE.
- DONE: frame_done=1 for exactly one cycle, busy=0, then return to IDLE.
- Latency: with start sampled at edge t, slot 0 with c=0 is visible in cycle t+1. A frame with no skips therefore lasts NUM_CHANNELS*STEP cycles, and frame_done follows in the next cycle.
- Strobes and curr_note are registered, with all bits 0 outside SLOT.
- carrier_word/mod_word are registered on the same edge that enters a slot. They hold through the slot and keep their last value after the frame ends.
- start while busy (SLOT or DONE): ignored; overrun pulses for one cycle and the frame continues undisturbed. start in IDLE has no other qualifier.
- An input change during a slot does not alter the presented words until the next slot entry.
- Sample-clock divider:
  - Free-running counter d counts 0..SCLK_DIV-1 and wraps; it is independent of the FSM.
  - s_clk = (d >= SCLK_DIV/2).
  - s_clk_pos=1 in the cycle after d==0; s_clk_neg=1 in the cycle after d==SCLK_DIV/2. Each pulse lasts one cycle.

Decomposition:
- Shared package fm_pkg holds:
  - FSM state encoding (IDLE/SLOT/DONE);
  - word-unpacking helper constants: note-enable bit position NUM_BITS-1;
  - default STEP/LATENCY values shared with the operator datapath.
- One sub-module, fm_next_channel: combinational search that, given the current index, eligibility mask and a from-zero flag, returns found plus the next index (lowest eligible index above the current one).

Test Plan:
- Reset, then start with skip_idle=0, NUM_CHANNELS=16, STEP=6, LATENCY=3 -> mod_acc_en[0] at t+1, mod_reg_en[0] at t+3, car_acc_en[0] at t+4, car_reg_en[0] at t+6, mod_acc_en[1] at t+7; frame_done at t+97; busy high t+1..t+96.
- skip_idle=1 with note_en set only on channels 2 and 9 -> exactly two slots (curr_ch=2, then 9), 12 cycles total, frame_done at t+13.
- skip_idle=1 with all note_en=0 -> no strobes; frame_done at t+1; busy never high.
- start reasserted mid-frame -> overrun single-cycle pulse; slot sequence and frame_done timing unchanged.
- rst asserted during slot 5 -> next cycle all outputs 0, no frame_done; a new start yields a normal frame from channel 0.
- Channel 3 carrier = 0xFFFF_FFFF, modulator = 0 -> during slot 3: carrier_word = 0x7FFF_FFFF, note_en[3]=1, mod_acc_clr[3]=1. SCLK_DIV=8 -> s_clk period 8 cycles, s_clk_pos and s_clk_neg 4 cycles apart.
